// File: rtl/iic_slave_pkg.sv
// Shared constants for the I2C EEPROM target: FSM encodings, byte framing and default device address.
package iic_slave_pkg;

   localparam logic [3:0] LP_ST_IDLE    = 4'd0;
   localparam logic [3:0] LP_ST_DEV     = 4'd1;
   localparam logic [3:0] LP_ST_DEV_ACK = 4'd2;
   localparam logic [3:0] LP_ST_AH      = 4'd3;
   localparam logic [3:0] LP_ST_AH_ACK  = 4'd4;
   localparam logic [3:0] LP_ST_AL      = 4'd5;
   localparam logic [3:0] LP_ST_AL_ACK  = 4'd6;
   localparam logic [3:0] LP_ST_WR      = 4'd7;
   localparam logic [3:0] LP_ST_WR_ACK  = 4'd8;
   localparam logic [3:0] LP_ST_RD      = 4'd9;
   localparam logic [3:0] LP_ST_RD_ACK  = 4'd10;
   localparam logic [3:0] LP_ST_WAIT    = 4'd11;

   typedef enum logic [3:0] {
      ST_IDLE    = LP_ST_IDLE,
      ST_DEV     = LP_ST_DEV,
      ST_DEV_ACK = LP_ST_DEV_ACK,
      ST_AH      = LP_ST_AH,
      ST_AH_ACK  = LP_ST_AH_ACK,
      ST_AL      = LP_ST_AL,
      ST_AL_ACK  = LP_ST_AL_ACK,
      ST_WR      = LP_ST_WR,
      ST_WR_ACK  = LP_ST_WR_ACK,
      ST_RD      = LP_ST_RD,
      ST_RD_ACK  = LP_ST_RD_ACK,
      ST_WAIT    = LP_ST_WAIT
   } state_t;

   localparam int         LP_BYTE_BITS = 8;
   localparam int         LP_RW_BIT    = 0;
   localparam logic [6:0] LP_DEV_ADDR  = 7'b1010000;

endpackage

// File: rtl/iic_eeprom_slave_if.sv
// Bus and memory-port bundle of the I2C EEPROM target; names are from the target's point of view.
interface iic_eeprom_slave_if #(
   parameter int P_ADDR_W = 13
);
   logic                i_iic_scl;
   logic                i_iic_sda;
   logic                o_iic_sda_oe;
   logic [P_ADDR_W-1:0] o_mem_addr;
   logic                o_mem_wen;
   logic [7:0]          o_mem_wdata;
   logic                o_mem_ren;
   logic [7:0]          i_mem_rdata;
   logic                o_busy;

   modport slave (
      input  i_iic_scl, i_iic_sda, i_mem_rdata,
      output o_iic_sda_oe, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_ren, o_busy
   );

   modport master (
      output i_iic_scl, i_iic_sda, i_mem_rdata,
      input  o_iic_sda_oe, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_ren, o_busy
   );
endinterface

// File: rtl/iic_bus_sync.sv
// Synchronizes raw SCL/SDA into the system clock and flags SCL edges plus START/STOP conditions.
module iic_bus_sync #(
   parameter int P_SYNC_STAGES = 2
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start_det,
   output logic o_stop_det,
   output logic o_sda_s
);
   logic [P_SYNC_STAGES-1:0] r_scl_sync;
   logic [P_SYNC_STAGES-1:0] r_sda_sync;
   logic                     r_scl_d;
   logic                     r_sda_d;
   logic                     w_scl_s;
   logic                     w_sda_s;

   assign w_scl_s = r_scl_sync[P_SYNC_STAGES-1];
   assign w_sda_s = r_sda_sync[P_SYNC_STAGES-1];

   // Lines reset to the idle-high level so leaving reset never fakes an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= (r_scl_sync << 1) | P_SYNC_STAGES'(i_scl);
         r_sda_sync <= (r_sda_sync << 1) | P_SYNC_STAGES'(i_sda);
         r_scl_d    <= w_scl_s;
         r_sda_d    <= w_sda_s;
      end
   end

   assign o_scl_rise  = ~r_scl_d & w_scl_s;
   assign o_scl_fall  = r_scl_d & ~w_scl_s;
   assign o_start_det = r_scl_d & w_scl_s & r_sda_d & ~w_sda_s;
   assign o_stop_det  = r_scl_d & w_scl_s & ~r_sda_d & w_sda_s;
   assign o_sda_s     = w_sda_s;

endmodule

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating an AT24C64 over an external synchronous memory port.
// Optional write protect input i_wp is enabled by defining IIC_EEPROM_SLAVE_WP_EN.
module iic_eeprom_slave
   import iic_slave_pkg::*;
#(
   parameter logic [6:0] P_DEV_ADDR    = LP_DEV_ADDR,
   parameter int         P_ADDR_W      = 13,
   parameter int         P_PAGE_W      = 5,
   parameter int         P_SYNC_STAGES = 2
)(
   input  logic              i_clk,
   input  logic              i_rst,
`ifdef IIC_EEPROM_SLAVE_WP_EN
   input  logic              i_wp,
`endif
   iic_eeprom_slave_if.slave bus
);
   state_t              r_state, w_state_nxt;
   logic [3:0]          r_bitcnt, w_bitcnt_nxt;
   logic [7:0]          r_shift, w_shift_nxt;
   logic [7:0]          r_addr_hi, w_addr_hi_nxt;
   logic [P_ADDR_W-1:0] r_ptr, w_ptr_nxt;
   logic [P_ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [7:0]          r_mem_wdata, w_mem_wdata_nxt;
   logic                r_sda_oe, w_sda_oe_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_mem_wen, w_mem_wen_nxt;
   logic                r_mem_ren, w_mem_ren_nxt;
   logic                r_rw, w_rw_nxt;
   logic                r_nack, w_nack_nxt;
   logic                r_latch, w_latch_nxt;
   logic                w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s, w_wp;
   logic [7:0]          w_byte;
   logic                w_byte_done;
   logic [P_ADDR_W-1:0] w_page_inc;

`ifdef IIC_EEPROM_SLAVE_WP_EN
   assign w_wp = i_wp;
`else
   assign w_wp = 1'b0;
`endif

   iic_bus_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_scl       (bus.i_iic_scl),
      .i_sda       (bus.i_iic_sda),
      .o_scl_rise  (w_scl_rise),
      .o_scl_fall  (w_scl_fall),
      .o_start_det (w_start),
      .o_stop_det  (w_stop),
      .o_sda_s     (w_sda_s)
   );

   assign w_byte      = {r_shift[6:0], w_sda_s};
   assign w_byte_done = (r_bitcnt == 4'(LP_BYTE_BITS - 1));
   assign w_page_inc  = {r_ptr[P_ADDR_W-1:P_PAGE_W], r_ptr[P_PAGE_W-1:0] + P_PAGE_W'(1)};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_addr_hi   <= '0;
         r_ptr       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_mem_ren   <= 1'b0;
         r_rw        <= 1'b0;
         r_nack      <= 1'b0;
         r_latch     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_addr_hi   <= w_addr_hi_nxt;
         r_ptr       <= w_ptr_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_busy      <= w_busy_nxt;
         r_mem_wen   <= w_mem_wen_nxt;
         r_mem_ren   <= w_mem_ren_nxt;
         r_rw        <= w_rw_nxt;
         r_nack      <= w_nack_nxt;
         r_latch     <= w_latch_nxt;
      end
   end

   // ACK slots use r_bitcnt as a phase: 0 = waiting for the fall after bit 8, 1 = after bit 9.
   always_comb begin
      w_state_nxt     = r_state;
      w_bitcnt_nxt    = r_bitcnt;
      w_shift_nxt     = r_shift;
      w_addr_hi_nxt   = r_addr_hi;
      w_ptr_nxt       = r_ptr;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_sda_oe_nxt    = r_sda_oe;
      w_busy_nxt      = r_busy;
      w_mem_wen_nxt   = 1'b0;
      w_mem_ren_nxt   = 1'b0;
      w_rw_nxt        = r_rw;
      w_nack_nxt      = r_nack;
      w_latch_nxt     = r_latch;

      if (w_stop) begin
         w_state_nxt  = ST_IDLE;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_latch_nxt  = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = ST_DEV;
         w_bitcnt_nxt = '0;
         w_sda_oe_nxt = 1'b0;
         w_latch_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_DEV, ST_AH, ST_AL, ST_WR: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = w_byte;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (w_byte_done) begin
                     w_bitcnt_nxt = '0;
                     w_nack_nxt   = 1'b0;
                     case (r_state)
                        ST_DEV: begin
                           if (w_byte[7:1] == P_DEV_ADDR) begin
                              w_state_nxt = ST_DEV_ACK;
                              w_rw_nxt    = w_byte[LP_RW_BIT];
                              w_busy_nxt  = 1'b1;
                           end else begin
                              w_state_nxt = ST_WAIT;
                           end
                        end
                        ST_AH: begin
                           w_addr_hi_nxt = w_byte;
                           w_state_nxt   = ST_AH_ACK;
                        end
                        ST_AL: begin
                           w_ptr_nxt   = P_ADDR_W'({r_addr_hi, w_byte});
                           w_state_nxt = ST_AL_ACK;
                        end
                        default: begin
                           w_nack_nxt = w_wp;
                           if (!w_wp) begin
                              w_mem_wen_nxt   = 1'b1;
                              w_mem_addr_nxt  = r_ptr;
                              w_mem_wdata_nxt = w_byte;
                           end
                           w_ptr_nxt   = w_page_inc;
                           w_state_nxt = ST_WR_ACK;
                        end
                     endcase
                  end
               end
            end
            ST_DEV_ACK, ST_AH_ACK, ST_AL_ACK, ST_WR_ACK: begin
               if (w_scl_fall) begin
                  if (r_bitcnt == 4'd0) begin
                     w_sda_oe_nxt = ~r_nack;
                     w_bitcnt_nxt = 4'd1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_bitcnt_nxt = '0;
                     case (r_state)
                        ST_DEV_ACK: begin
                           if (r_rw) begin
                              w_state_nxt    = ST_RD;
                              w_mem_ren_nxt  = 1'b1;
                              w_mem_addr_nxt = r_ptr;
                           end else begin
                              w_state_nxt = ST_AH;
                           end
                        end
                        ST_AH_ACK: w_state_nxt = ST_AL;
                        default:   w_state_nxt = ST_WR;
                     endcase
                  end
               end
            end
            // Read strobe, then one cycle later latch the byte and present bit 7.
            ST_RD: begin
               if (r_mem_ren) begin
                  w_latch_nxt = 1'b1;
               end else if (r_latch) begin
                  w_latch_nxt  = 1'b0;
                  w_shift_nxt  = bus.i_mem_rdata;
                  w_sda_oe_nxt = ~bus.i_mem_rdata[7];
               end else if (w_scl_rise) begin
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bitcnt == 4'(LP_BYTE_BITS)) begin
                     w_sda_oe_nxt = 1'b0;
                     w_bitcnt_nxt = '0;
                     w_state_nxt  = ST_RD_ACK;
                  end else begin
                     w_sda_oe_nxt = ~r_shift[6];
                     w_shift_nxt  = {r_shift[6:0], r_shift[7]};
                  end
               end
            end
            ST_RD_ACK: begin
               if (w_scl_rise) begin
                  if (!w_sda_s) begin
                     w_ptr_nxt    = r_ptr + P_ADDR_W'(1);
                     w_bitcnt_nxt = 4'd1;
                  end else begin
                     w_state_nxt = ST_WAIT;
                  end
               end else if (w_scl_fall && (r_bitcnt == 4'd1)) begin
                  w_bitcnt_nxt   = '0;
                  w_state_nxt    = ST_RD;
                  w_mem_ren_nxt  = 1'b1;
                  w_mem_addr_nxt = r_ptr;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.o_iic_sda_oe = r_sda_oe;
   assign bus.o_mem_addr   = r_mem_addr;
   assign bus.o_mem_wen    = r_mem_wen;
   assign bus.o_mem_wdata  = r_mem_wdata;
   assign bus.o_mem_ren    = r_mem_ren;
   assign bus.o_busy       = r_busy;

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: a bit-banged I2C master against a behavioural synchronous memory.
module tb_iic_eeprom_slave;

   localparam int ADDR_W = 13;
   localparam int QTR    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              scl;
   logic              masterSda;
   logic [7:0]        memRdata;
   logic [7:0]        mem [0:(1<<ADDR_W)-1];
`ifdef IIC_EEPROM_SLAVE_WP_EN
   logic              wp;
`endif

   int                checkCount = 0;
   int                errorCount = 0;
   int                wrCount = 0;
   int                rdCount = 0;
   int                oeLowCount = 0;
   logic [ADDR_W-1:0] wrAddr [0:63];
   logic [7:0]        wrData [0:63];
   logic [ADDR_W-1:0] rdAddr [0:63];

   iic_eeprom_slave_if #(.P_ADDR_W(ADDR_W)) ifc ();

   assign ifc.i_iic_scl   = scl;
   assign ifc.i_iic_sda   = masterSda & ~ifc.o_iic_sda_oe;
   assign ifc.i_mem_rdata = memRdata;

   iic_eeprom_slave #(
      .P_DEV_ADDR    (7'b1010000),
      .P_ADDR_W      (ADDR_W),
      .P_PAGE_W      (5),
      .P_SYNC_STAGES (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
`ifdef IIC_EEPROM_SLAVE_WP_EN
      .i_wp  (wp),
`endif
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   // Behavioural memory with a one-cycle read latency, plus strobe logging
   always @(posedge clk) begin
      if (ifc.o_mem_wen) begin
         mem[ifc.o_mem_addr] <= ifc.o_mem_wdata;
         if (wrCount < 64) begin
            wrAddr[wrCount] <= ifc.o_mem_addr;
            wrData[wrCount] <= ifc.o_mem_wdata;
         end
         wrCount <= wrCount + 1;
      end
      if (ifc.o_mem_ren) begin
         memRdata <= mem[ifc.o_mem_addr];
         if (rdCount < 64) rdAddr[rdCount] <= ifc.o_mem_addr;
         rdCount <= rdCount + 1;
      end
      if (ifc.o_iic_sda_oe) oeLowCount <= oeLowCount + 1;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sclVal, input logic sdaVal, input int cycles);
      scl       = sclVal;
      masterSda = sdaVal;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic iicStart();
      applyStimulus(scl, 1'b1, QTR);
      applyStimulus(1'b1, 1'b1, QTR);
      applyStimulus(1'b1, 1'b0, QTR);
      applyStimulus(1'b0, 1'b0, QTR);
   endtask

   task automatic iicStop();
      applyStimulus(1'b0, 1'b0, QTR);
      applyStimulus(1'b1, 1'b0, QTR);
      applyStimulus(1'b1, 1'b1, QTR);
   endtask

   task automatic iicWriteBit(input logic b);
      applyStimulus(1'b0, b, QTR);
      applyStimulus(1'b1, b, 2*QTR);
      applyStimulus(1'b0, b, QTR);
   endtask

   task automatic iicReadBit(output logic b);
      applyStimulus(1'b0, 1'b1, QTR);
      applyStimulus(1'b1, 1'b1, QTR);
      b = ifc.i_iic_sda;
      applyStimulus(1'b1, 1'b1, QTR);
      applyStimulus(1'b0, 1'b1, QTR);
   endtask

   task automatic iicWriteByte(input logic [7:0] data, output logic ack);
      for (int i = 7; i >= 0; i--) iicWriteBit(data[i]);
      iicReadBit(ack);
   endtask

   task automatic iicReadByte(input logic ackBit, output logic [7:0] data);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         iicReadBit(b);
         data[i] = b;
      end
      iicWriteBit(ackBit);
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] data;
      int         wrBase;
      int         rdBase;
      int         oeBase;

      rst       = 1'b1;
      scl       = 1'b1;
      masterSda = 1'b1;
`ifdef IIC_EEPROM_SLAVE_WP_EN
      wp        = 1'b0;
`endif
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rstOe",   32'(ifc.o_iic_sda_oe), 32'h0);
      checkOutput("rstBusy", 32'(ifc.o_busy),       32'h0);
      checkOutput("rstWen",  32'(ifc.o_mem_wen),    32'h0);
      checkOutput("rstRen",  32'(ifc.o_mem_ren),    32'h0);
      checkOutput("rstAddr", 32'(ifc.o_mem_addr),   32'h0);

      $display("[TB] byte write 0x0123 <= 0x5A");
      wrBase = wrCount;
      iicStart();
      iicWriteByte(8'hA0, ack); checkOutput("bwAckDev", 32'(ack), 32'h0);
      iicWriteByte(8'h01, ack); checkOutput("bwAckAh",  32'(ack), 32'h0);
      iicWriteByte(8'h23, ack); checkOutput("bwAckAl",  32'(ack), 32'h0);
      iicWriteByte(8'h5A, ack); checkOutput("bwAckDat", 32'(ack), 32'h0);
      checkOutput("bwBusy", 32'(ifc.o_busy), 32'h1);
      iicStop();
      checkOutput("bwCount", 32'(wrCount - wrBase),  32'd1);
      checkOutput("bwAddr",  32'(wrAddr[wrBase]),    32'h0123);
      checkOutput("bwData",  32'(wrData[wrBase]),    32'h5A);
      checkOutput("bwBusyOff", 32'(ifc.o_busy),      32'h0);

      $display("[TB] page wrap from 0x001F");
      wrBase = wrCount;
      iicStart();
      iicWriteByte(8'hA0, ack); checkOutput("pwAckDev", 32'(ack), 32'h0);
      iicWriteByte(8'h00, ack);
      iicWriteByte(8'h1F, ack);
      iicWriteByte(8'h11, ack); checkOutput("pwAck0", 32'(ack), 32'h0);
      iicWriteByte(8'h22, ack); checkOutput("pwAck1", 32'(ack), 32'h0);
      iicWriteByte(8'h33, ack); checkOutput("pwAck2", 32'(ack), 32'h0);
      iicStop();
      checkOutput("pwCount", 32'(wrCount - wrBase),   32'd3);
      checkOutput("pwAddr0", 32'(wrAddr[wrBase]),     32'h001F);
      checkOutput("pwAddr1", 32'(wrAddr[wrBase + 1]), 32'h0000);
      checkOutput("pwAddr2", 32'(wrAddr[wrBase + 2]), 32'h0001);
      checkOutput("pwData1", 32'(wrData[wrBase + 1]), 32'h22);

      $display("[TB] preload 0x0456/0x0457 and random read");
      wrBase = wrCount;
      iicStart();
      iicWriteByte(8'hA0, ack);
      iicWriteByte(8'h04, ack);
      iicWriteByte(8'h56, ack);
      iicWriteByte(8'hC3, ack);
      iicWriteByte(8'h3C, ack);
      iicStop();
      checkOutput("plAddr1", 32'(wrAddr[wrBase + 1]), 32'h0457);

      rdBase = rdCount;
      iicStart();
      iicWriteByte(8'hA0, ack);
      iicWriteByte(8'h04, ack);
      iicWriteByte(8'h56, ack); checkOutput("rrAckAl", 32'(ack), 32'h0);
      iicStart();
      iicWriteByte(8'hA1, ack); checkOutput("rrAckDev", 32'(ack), 32'h0);
      checkOutput("rrBusy", 32'(ifc.o_busy), 32'h1);
      iicReadByte(1'b0, data);  checkOutput("rrData0", 32'(data), 32'hC3);
      iicReadByte(1'b1, data);  checkOutput("rrData1", 32'(data), 32'h3C);
      iicStop();
      checkOutput("rrCount", 32'(rdCount - rdBase),   32'd2);
      checkOutput("rrAddr0", 32'(rdAddr[rdBase]),     32'h0456);
      checkOutput("rrAddr1", 32'(rdAddr[rdBase + 1]), 32'h0457);

      $display("[TB] device address mismatch");
      wrBase = wrCount;
      rdBase = rdCount;
      oeBase = oeLowCount;
      iicStart();
      iicWriteByte(8'hA2, ack); checkOutput("mmAck", 32'(ack), 32'h1);
      checkOutput("mmBusy", 32'(ifc.o_busy), 32'h0);
      iicWriteByte(8'h00, ack);
      iicStop();
      checkOutput("mmOeLow",  32'(oeLowCount - oeBase), 32'd0);
      checkOutput("mmWrites", 32'(wrCount - wrBase),    32'd0);
      checkOutput("mmReads",  32'(rdCount - rdBase),    32'd0);

      $display("[TB] reset in the middle of a read");
      iicStart();
      iicWriteByte(8'hA0, ack);
      iicWriteByte(8'h04, ack);
      iicWriteByte(8'h56, ack);
      iicStart();
      iicWriteByte(8'hA1, ack);
      iicReadBit(b); checkOutput("mrBit7", 32'(b), 32'h1);
      iicReadBit(b); checkOutput("mrBit6", 32'(b), 32'h1);
      checkOutput("mrDrive0", 32'(ifc.o_iic_sda_oe), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mrOeRelease", 32'(ifc.o_iic_sda_oe), 32'h0);
      scl       = 1'b1;
      masterSda = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (2*QTR) @(negedge clk);
      checkOutput("mrBusy", 32'(ifc.o_busy), 32'h0);

      rdBase = rdCount;
      iicStart();
      iicWriteByte(8'hA1, ack); checkOutput("crAckDev", 32'(ack), 32'h0);
      iicReadByte(1'b1, data);  checkOutput("crData", 32'(data), 32'h22);
      iicStop();
      checkOutput("crAddr", 32'(rdAddr[rdBase]), 32'h0000);

`ifdef IIC_EEPROM_SLAVE_WP_EN
      $display("[TB] write protect");
      wp     = 1'b1;
      wrBase = wrCount;
      iicStart();
      iicWriteByte(8'hA0, ack); checkOutput("wpAckDev", 32'(ack), 32'h0);
      iicWriteByte(8'h00, ack); checkOutput("wpAckAh",  32'(ack), 32'h0);
      iicWriteByte(8'h10, ack); checkOutput("wpAckAl",  32'(ack), 32'h0);
      iicWriteByte(8'h77, ack); checkOutput("wpNackDat", 32'(ack), 32'h1);
      iicStop();
      checkOutput("wpWrites", 32'(wrCount - wrBase), 32'd0);
      wp = 1'b0;
`endif

      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/iic_eeprom_slave.md
Name: iic_eeprom_slave

Overview:
- Synthesizable I2C target (responder) emulating the AT24C64 protocol seen from the bus.
- Counterpart to the team's EEPROM master: same 7-bit device address, two-byte word address, byte/page write, current/random/sequential read.
- SCL/SDA are oversampled in the i_clk domain; storage is external through a simple synchronous memory port.
- Serves as a loopback target for board bring-up and as an RTL bench partner for the master driver.

Parameters:
- P_DEV_ADDR, 7'b1010000, device address matched against the first byte after START.
- P_ADDR_W, 13, word-address width; upper bits of the high address byte are ignored.
- P_PAGE_W, 5, log2 of the write page size (32 bytes).
- P_SYNC_STAGES, 2, synchronizer depth on SCL and SDA.

Ports:
- i_clk  in  1  system clock; must be at least 16× SCL.
- i_rst  in  1  synchronous reset, active-high.
- i_iic_scl  in  1  bus SCL (raw).
- i_iic_sda  in  1  bus SDA (raw).
- o_iic_sda_oe  out  1  1 = pull SDA low; 0 = release to the pull-up.
- o_mem_addr  out  P_ADDR_W  memory address.
- o_mem_wen  out  1  one-cycle write strobe.
- o_mem_wdata  out  8  write data.
- o_mem_ren  out  1  one-cycle read strobe.
- i_mem_rdata  in  8  read data, valid exactly 1 cycle after o_mem_ren.
- o_busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset values:
  - all outputs 0; address pointer 0; FSM in IDLE; SDA released.
  - A reset mid-transfer releases SDA in the cycle after i_rst is sampled.
- Bus events (on synchronized signals):
  - SCL rise/fall detected by comparing consecutive samples.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Event latency: P_SYNC_STAGES+1 cycles.
- Timing rules:
  - Bits are sampled on SCL rise.
  - SDA is changed only on the cycle after an SCL fall.
- FSM states: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WR, WR_ACK, RD, RD_ACK, WAIT.
- Global event priority:
  - STOP in any state → IDLE, SDA released, o_busy=0.
  - START in any state → DEV with bit counter 0. This covers repeated START.
  - START/STOP take priority over a coincident SCL edge.
- DEV: shift 8 bits MSB first.
  - On a match with R/W=0 → DEV_ACK, then AH.
  - On a match with R/W=1 → DEV_ACK, then RD.
  - On a mismatch → WAIT (no ACK, SDA untouched) until START/STOP.
- ACK slots:
  - oe=1 from the SCL fall after bit 8 until the SCL fall after bit 9.
- AH/AL: shift high and low address bytes, then load the pointer. Excess MSBs are discarded.
- Write path:
  - After AL_ACK, go to WR.
  - Each WR byte produces an o_mem_wen pulse on the SCL rise of bit 8 (addr = pointer), then WR_ACK.
  - The pointer increments only its low P_PAGE_W bits, wrapping inside the page (31 → 0 within the page).
- Random read: master issues repeated START + DEV with R=1. The pointer is kept.
- Read path:
  - Entering RD: o_mem_ren pulses on the first cycle; data is latched 1 cycle later into the shift register.
  - Bit 7 is driven on the first SCL low. A 0 bit sets oe=1; a 1 bit sets oe=0.
  - After 8 bits, release SDA for the master ACK and sample it on the 9th SCL rise.
  - ACK (0): increment the full pointer, wrapping 2^P_ADDR_W-1 → 0. Prefetch on the SCL fall and continue RD.
  - NACK (1): WAIT.
- Slave never stretches SCL. Bytes interrupted by START/STOP are discarded with no memory write.

Optional Feature:
- Macro: IIC_EEPROM_SLAVE_WP_EN.
- Defined: adds input i_wp (1 bit).
  - While i_wp=1, WR bytes are NACKed (SDA released in the ACK slot) and o_mem_wen is suppressed.
  - The pointer still advances.
  - Device and address bytes are still ACKed.
- Undefined: no i_wp port; writes are always performed and ACKed.

Decomposition:
- Package iic_slave_pkg:
  - FSM state encodings (4-bit localparams).
  - Byte bit count 8; R/W bit index 0.
  - Default device address 7'b1010000.
- Sub-module iic_bus_sync:
  - P_SYNC_STAGES flops per line.
  - Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
  - Instantiated once; the FSM stays in iic_eeprom_slave.

Test Plan:
- Byte write: START, 0xA0, 0x01, 0x23, 0x5A, STOP → four ACKs; single o_mem_wen with addr 0x0123, wdata 0x5A; o_busy falls after STOP.
- Page wrap: write 3 bytes from addr 0x001F → writes hit 0x001F, 0x0000, 0x0001 with page bits wrapping and upper bits unchanged.
- Random read: preload mem[0x0456]=0xC3, mem[0x0457]=0x3C; run A0, 04, 56, reSTART, A1, read with master ACK then NACK, STOP → SDA carries 0xC3 then 0x3C; two o_mem_ren pulses.
- Address mismatch: START, 0xA2 → SDA never driven low; no memory strobes; WAIT until STOP.
- Reset mid-read: assert i_rst while driving a 0 bit → o_iic_sda_oe=0 the next cycle; the next transaction starts at pointer 0.
- WP (macro defined, i_wp=1): A0, 00, 10, 0x77 → data byte NACKed; o_mem_wen never pulses.
